// File: rtl/ecsu_persist_monitor.sv
// ECSU weather/emergency classifier with escalation persistence, de-escalation hold
// and an acknowledged EMERGENCY exit.
module ecsu_persist_monitor #(
   parameter int WIND_W        = 6,
   parameter int TEMP_W        = 8,
   parameter int WIND_CAUTION  = 10,
   parameter int WIND_SEVERE   = 15,
   parameter int WIND_EMERG    = 20,
   parameter int TEMP_HI       = 35,
   parameter int TEMP_LO       = -35,
   parameter int TEMP_EMERG_LO = -40,
   parameter int PERSIST       = 2,
   parameter int CLEAR_HOLD    = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              thunderstorm,
   input  logic [WIND_W-1:0] wind,
   input  logic [1:0]        visibility,
   input  logic [TEMP_W-1:0] temperature,
   input  logic              ack,
   output logic              severe_weather,
   output logic              emergency_landing_alert,
   output logic [1:0]        ECSU_state,
   output logic              state_change
);

   localparam int MAX_HOLD = (PERSIST > CLEAR_HOLD) ? PERSIST : CLEAR_HOLD;
   localparam int CNT_W    = $clog2(MAX_HOLD) + 1;

   localparam logic        [WIND_W-1:0] W_CAUTION = WIND_W'(WIND_CAUTION);
   localparam logic        [WIND_W-1:0] W_SEVERE  = WIND_W'(WIND_SEVERE);
   localparam logic        [WIND_W-1:0] W_EMERG   = WIND_W'(WIND_EMERG);
   localparam logic signed [TEMP_W-1:0] T_HI      = TEMP_W'(TEMP_HI);
   localparam logic signed [TEMP_W-1:0] T_LO      = TEMP_W'(TEMP_LO);
   localparam logic signed [TEMP_W-1:0] T_ELO     = TEMP_W'(TEMP_EMERG_LO);

   typedef enum logic [1:0] {
      ALL_CLEAR  = 2'b00,
      CAUTION    = 2'b01,
      HIGH_ALERT = 2'b10,
      EMERGENCY  = 2'b11
   } ecsu_state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'b00,
      DIR_UP   = 2'b01,
      DIR_DOWN = 2'b10
   } dir_t;

   ecsu_state_t      state, state_next, tgt;
   dir_t             dir, dir_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             change_next;
   logic             caution_cond, severe_cond, emerg_cond;
   logic signed [TEMP_W-1:0] temp_s;

   assign temp_s       = $signed(temperature);
   assign caution_cond = (wind > W_CAUTION) || (visibility == 2'b01);
   assign severe_cond  = thunderstorm || (wind > W_SEVERE) || (temp_s > T_HI) ||
                         (temp_s < T_LO) || (visibility == 2'b11);
   assign emerg_cond   = (wind > W_EMERG) || (temp_s < T_ELO);

   // Target level; EMERGENCY is reachable only once HIGH_ALERT has been reached.
   always_comb begin
      tgt = ALL_CLEAR;
      if (emerg_cond)        tgt = EMERGENCY;
      else if (severe_cond)  tgt = HIGH_ALERT;
      else if (caution_cond) tgt = CAUTION;
      if ((state < HIGH_ALERT) && (tgt == EMERGENCY)) tgt = HIGH_ALERT;
   end

   // A request that reverses direction restarts from zero on that edge.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      dir_next    = dir;
      change_next = 1'b0;
      if (state == EMERGENCY) begin
         cnt_next = '0;
         dir_next = DIR_NONE;
         if (ack && !emerg_cond && !severe_cond) begin
            state_next  = HIGH_ALERT;
            change_next = 1'b1;
         end
      end else if (tgt > state) begin
         if (dir == DIR_DOWN) begin
            cnt_next = '0;
            dir_next = DIR_UP;
         end else if (cnt == CNT_W'(PERSIST - 1)) begin
            state_next  = tgt;
            cnt_next    = '0;
            dir_next    = DIR_NONE;
            change_next = 1'b1;
         end else begin
            cnt_next = cnt + CNT_W'(1);
            dir_next = DIR_UP;
         end
      end else if (tgt < state) begin
         if (dir == DIR_UP) begin
            cnt_next = '0;
            dir_next = DIR_DOWN;
         end else if (cnt == CNT_W'(CLEAR_HOLD - 1)) begin
            state_next  = ecsu_state_t'(state - 2'd1);
            cnt_next    = '0;
            dir_next    = DIR_NONE;
            change_next = 1'b1;
         end else begin
            cnt_next = cnt + CNT_W'(1);
            dir_next = DIR_DOWN;
         end
      end else begin
         cnt_next = '0;
         dir_next = DIR_NONE;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state          <= ALL_CLEAR;
         cnt            <= '0;
         dir            <= DIR_NONE;
         severe_weather <= 1'b0;
         state_change   <= 1'b0;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         dir            <= dir_next;
         severe_weather <= severe_cond;
         state_change   <= change_next;
      end
   end

   assign ECSU_state              = state;
   assign emergency_landing_alert = (state == EMERGENCY);

endmodule
